// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: FSM state encoding,
// RV32I load/store width codes and the store lane/mask helpers.
// Optional build macro: LSU_MISALIGN_TRAP_EN adds the misalignment check helper.
package rv32i_types;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_DONE   = 2'd2
  } lsu_state_t;

  // Byte enables; a shifted half/byte mask falls off the top when misaligned.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (store_funct3_t'(f3))
      ST_SB:   m = 4'b0001 << off;
      ST_SH:   m = 4'b0011 << off;
      ST_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Byte/half stores are replicated so every lane carries the value.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (store_funct3_t'(f3))
      ST_SB:   w = {4{d[7:0]}};
      ST_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Width code low bits: 01 = half, 10 = word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
  endfunction
`endif

endpackage

// File: rtl/dmem_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface dmem_lsu_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/dmem_lsu_load_align.sv
// Load alignment: picks the byte/half lane addressed by the offset and
// sign- or zero-extends it according to the load width code.
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);
  logic [15:0] lane;

  assign lane = 16'(rdata_i >> {offset_i, 3'b000});

  // Extend the selected lane; full-word loads pass the bus word through.
  always_comb begin
    result_o = rdata_i;
    case (load_funct3_t'(funct3_i))
      LD_LB:   result_o = {{24{lane[7]}}, lane[7:0]};
      LD_LH:   result_o = {{16{lane[15]}}, lane};
      LD_LBU:  result_o = {24'd0, lane[7:0]};
      LD_LHU:  result_o = {16'd0, lane};
      default: result_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: memory-stage load/store unit. Captures one request, holds the
// bus strobe until dmem_resp (or a MAX_WAIT-cycle timeout), then pulses done_o.
// Optional build macro: LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module dmem_lsu
  import rv32i_types::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        dmem_read_i,
  input  logic        dmem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  dmem_lsu_if.master  dmem,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       sdata_q, sdata_d;
  logic              is_load_q, is_load_d;

  logic              req;
  logic              in_access;
  logic              store_active;
  logic [31:0]       aligned;

  assign req          = valid_i & (dmem_read_i | dmem_write_i);
  assign in_access    = (state_q == LSU_ACCESS);
  assign store_active = in_access & ~is_load_q;

  load_align u_load_align (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .result_o (aligned)
  );

  // Bus is driven only while a transfer is in flight; zero otherwise.
  assign dmem.dmem_address = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_read    = in_access & is_load_q;
  assign dmem.dmem_write   = store_active;
  assign dmem.dmem_wmask   = store_active ? store_mask(funct3_q, addr_q[1:0]) : 4'b0000;
  assign dmem.dmem_wdata   = store_active ? store_wdata(funct3_q, sdata_q) : 32'd0;

  assign stall_o     = rst & (((state_q == LSU_IDLE) & req) | in_access);
  assign done_o      = (state_q == LSU_DONE);
  assign err_o       = err_q;
  assign load_data_o = load_data_q;

  // Next-state, request capture, wait counter and result/error updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    sdata_d     = sdata_q;
    is_load_d   = is_load_q;
    case (state_q)
      LSU_IDLE: begin
        if (req) begin
          addr_d    = addr_i;
          funct3_d  = funct3_i;
          sdata_d   = store_data_i;
          is_load_d = dmem_read_i;   // read wins when both are set
          cnt_d     = '0;
          state_d   = LSU_ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned(funct3_i[1:0], addr_i[1:0])) begin
            state_d     = LSU_DONE;
            err_d       = 1'b1;
            load_data_d = '0;
          end
`endif
        end
      end
      LSU_ACCESS: begin
        if (dmem.dmem_resp) begin
          state_d     = LSU_DONE;
          load_data_d = is_load_q ? aligned : 32'd0;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d     = LSU_DONE;
          err_d       = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  // Captured request fields; only observed while in ACCESS, so no reset.
  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    funct3_q  <= funct3_d;
    sdata_q   <= sdata_d;
    is_load_q <= is_load_d;
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu (MAX_WAIT = 4): a vector table of single
// transactions plus hand sequences for reset, back-to-back and stray resp.
`timescale 1ns/1ps
module tb_dmem_lsu;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        rd_i;
  logic        wr_i;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  dmem_lsu_if dmem_bus ();

  dmem_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .dmem_read_i  (rd_i),
    .dmem_write_i (wr_i),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .store_data_i (sdata),
    .dmem         (dmem_bus),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdat;
    int          resp_at;   // ACCESS cycle (1-based) carrying dmem_resp; 0 = never
    logic [31:0] e_addr;
    logic        e_rd;
    logic        e_wr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic        chk_w;
    logic [31:0] e_load;
    logic        chk_l;
    int          e_stall;
    int          e_acc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rdat,
                              input int resp_at, input logic [31:0] e_addr,
                              input logic e_rd, input logic e_wr, input logic [3:0] e_mask,
                              input logic [31:0] e_wdata, input logic chk_w,
                              input logic [31:0] e_load, input logic chk_l,
                              input int e_stall, input int e_acc, input logic e_err);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.sd = sd; v.rdat = rdat;
    v.resp_at = resp_at; v.e_addr = e_addr; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_mask = e_mask; v.e_wdata = e_wdata; v.chk_w = chk_w; v.e_load = e_load;
    v.chk_l = chk_l; v.e_stall = e_stall; v.e_acc = e_acc; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int          stalls, dones, acc;
    logic        seen_rd, seen_wr, unstable;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_mask;
    bit          fin;
    stalls = 0; dones = 0; acc = 0; seen_rd = 0; seen_wr = 0; unstable = 0;
    s_addr = '0; s_wdata = '0; s_mask = '0; fin = 0;
    valid_i = 1'b1; rd_i = v.rd; wr_i = v.wr; funct3 = v.f3; addr = v.a; sdata = v.sd;
    dmem_bus.dmem_rdata = v.rdat;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (done_o) begin
        dones++;
        fin = 1;
      end
      if (dmem_bus.dmem_read || dmem_bus.dmem_write) begin
        acc++;
        if (acc == 1) begin
          s_addr = dmem_bus.dmem_address; s_mask = dmem_bus.dmem_wmask;
          s_wdata = dmem_bus.dmem_wdata;
        end else if (s_addr !== dmem_bus.dmem_address || s_mask !== dmem_bus.dmem_wmask ||
                     s_wdata !== dmem_bus.dmem_wdata) begin
          unstable = 1;
        end
        seen_rd |= dmem_bus.dmem_read;
        seen_wr |= dmem_bus.dmem_write;
        dmem_bus.dmem_resp = (v.resp_at == acc);
      end
      tick();
      valid_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0;
      dmem_bus.dmem_resp = 1'b0;
    end
    chk({v.name, " access_cycles"}, 32'(acc), 32'(v.e_acc));
    chk({v.name, " dmem_read"}, 32'(seen_rd), 32'(v.e_rd));
    chk({v.name, " dmem_write"}, 32'(seen_wr), 32'(v.e_wr));
    chk({v.name, " address"}, s_addr, v.e_addr);
    chk({v.name, " wmask"}, 32'(s_mask), 32'(v.e_mask));
    if (v.chk_w) chk({v.name, " wdata"}, s_wdata, v.e_wdata);
    chk({v.name, " bus_stable"}, 32'(unstable), 32'd0);
    chk({v.name, " stall_cycles"}, 32'(stalls), 32'(v.e_stall));
    chk({v.name, " done_pulses"}, 32'(dones), 32'd1);
    if (v.chk_l) chk({v.name, " load_data"}, load_data_o, v.e_load);
    chk({v.name, " err"}, 32'(err_o), 32'(v.e_err));
    @(negedge clk);
    chk({v.name, " done_after"}, 32'(done_o), 32'd0);
    chk({v.name, " stall_after"}, 32'(stall_o), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; valid_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0; funct3 = 3'd0;
    addr = '0; sdata = '0;
    dmem_bus.dmem_rdata = '0; dmem_bus.dmem_resp = 1'b0;

    // name rd wr f3 addr sdata rdata resp_at | e_addr rd wr mask wdata chk_w load chk_l stall acc err
    vecs.push_back(mk("sw_100",   0,1,3'd2,32'h100,32'hDEADBEEF,32'h0,       3, 32'h100,0,1,4'b1111,32'hDEADBEEF,1,32'h0,0,4,3,0));
    vecs.push_back(mk("sb_103",   0,1,3'd0,32'h103,32'h000000AB,32'h0,       1, 32'h100,0,1,4'b1000,32'hABABABAB,1,32'h0,0,2,1,0));
    vecs.push_back(mk("sh_102",   0,1,3'd1,32'h102,32'h1234CAFE,32'h0,       2, 32'h100,0,1,4'b1100,32'hCAFECAFE,1,32'h0,0,3,2,0));
    vecs.push_back(mk("sb_201",   0,1,3'd0,32'h201,32'h00000055,32'h0,       1, 32'h200,0,1,4'b0010,32'h55555555,1,32'h0,0,2,1,0));
    vecs.push_back(mk("lb_102",   1,0,3'd0,32'h102,32'h0,       32'h00800000,1, 32'h100,1,0,4'b0000,32'h0,0,32'hFFFFFF80,1,2,1,0));
    vecs.push_back(mk("lbu_102",  1,0,3'd4,32'h102,32'h0,       32'h00800000,1, 32'h100,1,0,4'b0000,32'h0,0,32'h00000080,1,2,1,0));
    vecs.push_back(mk("lh_202",   1,0,3'd1,32'h202,32'h0,       32'h8001FFFF,2, 32'h200,1,0,4'b0000,32'h0,0,32'hFFFF8001,1,3,2,0));
    vecs.push_back(mk("lhu_202",  1,0,3'd5,32'h202,32'h0,       32'h8001FFFF,2, 32'h200,1,0,4'b0000,32'h0,0,32'h00008001,1,3,2,0));
    vecs.push_back(mk("lw_304",   1,0,3'd2,32'h304,32'h0,       32'h12345678,3, 32'h304,1,0,4'b0000,32'h0,0,32'h12345678,1,4,3,0));
    vecs.push_back(mk("rdwr_both",1,1,3'd2,32'h010,32'hFFFFFFFF,32'hCAFEF00D,1, 32'h010,1,0,4'b0000,32'h0,0,32'hCAFEF00D,1,2,1,0));
    vecs.push_back(mk("lb_101",   1,0,3'd0,32'h101,32'h0,       32'h00007F00,1, 32'h100,1,0,4'b0000,32'h0,0,32'h0000007F,1,2,1,0));
    vecs.push_back(mk("lh_200",   1,0,3'd1,32'h200,32'h0,       32'h1234ABCD,1, 32'h200,1,0,4'b0000,32'h0,0,32'hFFFFABCD,1,2,1,0));
    vecs.push_back(mk("lbu_103",  1,0,3'd4,32'h103,32'h0,       32'hC3000000,1, 32'h100,1,0,4'b0000,32'h0,0,32'h000000C3,1,2,1,0));
    vecs.push_back(mk("timeout",  1,0,3'd1,32'h202,32'h0,       32'h8001FFFF,0, 32'h200,1,0,4'b0000,32'h0,0,32'h0,1,5,4,1));

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst address", dmem_bus.dmem_address, 32'h0);
    chk("rst read", 32'(dmem_bus.dmem_read), 32'd0);
    chk("rst write", 32'(dmem_bus.dmem_write), 32'd0);
    chk("rst wmask", 32'(dmem_bus.dmem_wmask), 32'd0);
    chk("rst wdata", dmem_bus.dmem_wdata, 32'h0);
    chk("rst stall", 32'(stall_o), 32'd0);
    chk("rst load_data", load_data_o, 32'h0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // valid without a memory op is not a request
    valid_i = 1'b1; rd_i = 1'b0; wr_i = 1'b0;
    @(negedge clk);
    chk("noop stall", 32'(stall_o), 32'd0);
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    chk("noop read", 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 32'd0);
    tick();

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Reset while in ACCESS
    valid_i = 1'b1; rd_i = 1'b1; wr_i = 1'b0; funct3 = 3'd2; addr = 32'h80;
    @(negedge clk);
    tick();
    valid_i = 1'b0; rd_i = 1'b0;
    @(negedge clk);
    chk("midrst pre_read", 32'(dmem_bus.dmem_read), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst read", 32'(dmem_bus.dmem_read), 32'd0);
    chk("midrst write", 32'(dmem_bus.dmem_write), 32'd0);
    chk("midrst stall", 32'(stall_o), 32'd0);
    chk("midrst done", 32'(done_o), 32'd0);
    chk("midrst err", 32'(err_o), 32'd0);
    chk("midrst address", dmem_bus.dmem_address, 32'h0);
    tick();
    @(negedge clk);
    chk("midrst idle_done", 32'(done_o), 32'd0);
    tick();

    // Back-to-back: store, then a load presented during DONE
    valid_i = 1'b1; wr_i = 1'b1; rd_i = 1'b0; funct3 = 3'd2; addr = 32'h40; sdata = 32'h11223344;
    @(negedge clk);
    chk("b2b req_stall", 32'(stall_o), 32'd1);
    tick();
    @(negedge clk);
    chk("b2b write", 32'(dmem_bus.dmem_write), 32'd1);
    chk("b2b wdata", dmem_bus.dmem_wdata, 32'h11223344);
    dmem_bus.dmem_resp = 1'b1;
    tick();
    dmem_bus.dmem_resp = 1'b0;
    wr_i = 1'b0; rd_i = 1'b1; funct3 = 3'd0; dmem_bus.dmem_rdata = 32'h000000F0;
    @(negedge clk);
    chk("b2b done1", 32'(done_o), 32'd1);
    chk("b2b done_stall", 32'(stall_o), 32'd0);
    chk("b2b done_write", 32'(dmem_bus.dmem_write), 32'd0);
    tick();
    @(negedge clk);
    chk("b2b accept_stall", 32'(stall_o), 32'd1);
    chk("b2b accept_read", 32'(dmem_bus.dmem_read), 32'd0);
    tick();
    valid_i = 1'b0; rd_i = 1'b0;
    @(negedge clk);
    chk("b2b read", 32'(dmem_bus.dmem_read), 32'd1);
    chk("b2b address", dmem_bus.dmem_address, 32'h40);
    dmem_bus.dmem_resp = 1'b1;
    tick();
    dmem_bus.dmem_resp = 1'b0;
    @(negedge clk);
    chk("b2b done2", 32'(done_o), 32'd1);
    chk("b2b load", load_data_o, 32'hFFFFFFF0);
    tick();

    // Stray resp in IDLE is ignored
    dmem_bus.dmem_rdata = 32'h12345678; dmem_bus.dmem_resp = 1'b1;
    @(negedge clk);
    chk("stray strobe", 32'(dmem_bus.dmem_read | dmem_bus.dmem_write), 32'd0);
    tick();
    dmem_bus.dmem_resp = 1'b0;
    @(negedge clk);
    chk("stray done", 32'(done_o), 32'd0);
    chk("stray load", load_data_o, 32'hFFFFFFF0);
    chk("stray err", 32'(err_o), 32'd0);
    tick();

    // Misaligned access
`ifdef LSU_MISALIGN_TRAP_EN
    run_vec(mk("trap_lw", 1,0,3'd2,32'h101,32'h0,32'hFFFFFFFF,1, 32'h0,0,0,4'b0000,32'h0,0,32'h0,0,1,0,1));
`else
    run_vec(mk("mis_sh", 0,1,3'd1,32'h103,32'h0000BEEF,32'h0,1, 32'h100,0,1,4'b1000,32'hBEEFBEEF,1,32'h0,0,2,1,0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
